xreg_ctrl: RTL

Sequencer for the X register bit-slice array in the discrete CPU datapath.
- Accepts one command at a time from the microsequencer over a valid/ready handshake.
- Drives the one-hot next-value selects (xiz/xip/xis/xid), the write clock wrx and the address-bus read enable rdx.
- Guarantees select setup/hold around every wrx edge, and arbitrates for the shared address bus before asserting rdx.

---
 rtl/xreg_ctrl_pkg.sv | 39 +++
 rtl/xreg_strobe_gen.sv | 79 +++++++
 rtl/xreg_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/xreg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xreg_ctrl_pkg
// Description : Opcodes, FSM state codes and one-hot select encodings shared
//               by the X register controller and its strobe generator.
// Revision    : 1.0 - initial release
// ============================================================================
package xreg_ctrl_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_CLR = 3'd1;
    localparam logic [2:0] OP_LDP = 3'd2;
    localparam logic [2:0] OP_LDD = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_RD  = 3'd5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_REQ    = 3'd4;
    localparam state_t ST_DRIVE  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    // Bit order is {xiz, xip, xis, xid}
    localparam logic [3:0] SEL_NONE  = 4'b0000;
    localparam logic [3:0] SEL_ZERO  = 4'b1000;
    localparam logic [3:0] SEL_P     = 4'b0100;
    localparam logic [3:0] SEL_SHIFT = 4'b0010;
    localparam logic [3:0] SEL_DATA  = 4'b0001;

    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_CLR) || (op == OP_LDP) || (op == OP_LDD) || (op == OP_SHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xreg_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : xreg_strobe_gen
// Description : SETUP/STROBE/HOLD timing sequencer producing the register
//               write clock and a strobe_done indication during HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module xreg_strobe_gen
    import xreg_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    output logic wrx,
    output logic setup_last,
    output logic pulse_last,
    output logic strobe_done
);

    localparam int c_MAXC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_CW   = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

    localparam logic [1:0] c_PH_IDLE   = 2'd0;
    localparam logic [1:0] c_PH_SETUP  = 2'd1;
    localparam logic [1:0] c_PH_STROBE = 2'd2;
    localparam logic [1:0] c_PH_HOLD   = 2'd3;

    logic [1:0]      r_phase;
    logic [c_CW-1:0] r_cnt;
    logic            r_wrx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_phase <= c_PH_IDLE;
            r_cnt   <= '0;
            r_wrx   <= 1'b0;
        end else begin
            case (r_phase)
                c_PH_IDLE, c_PH_HOLD: begin
                    // A new start in HOLD chains straight into the next shift step
                    if (start) begin
                        r_phase <= c_PH_SETUP;
                        r_cnt   <= c_CW'(SETUP_CYC - 1);
                    end else begin
                        r_phase <= c_PH_IDLE;
                    end
                end
                c_PH_SETUP: begin
                    if (r_cnt == '0) begin
                        r_phase <= c_PH_STROBE;
                        r_cnt   <= c_CW'(PULSE_CYC - 1);
                        r_wrx   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_PH_STROBE: begin
                    if (r_cnt == '0) begin
                        r_phase <= c_PH_HOLD;
                        r_wrx   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_phase <= c_PH_IDLE;
            endcase
        end
    end

    assign wrx         = r_wrx;
    assign setup_last  = (r_phase == c_PH_SETUP)  && (r_cnt == '0);
    assign pulse_last  = (r_phase == c_PH_STROBE) && (r_cnt == '0);
    assign strobe_done = (r_phase == c_PH_HOLD);

endmodule
`default_nettype wire

// File: rtl/xreg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xreg_ctrl
// Description : Command sequencer for the X register bit-slice array: select
//               timing around wrx, shift repetition and arbitrated bus reads.
//               Optional grant timeout: define XREG_CTRL_GNT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xreg_ctrl
    import xreg_ctrl_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 1,
    parameter int GNT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_count,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       xiz,
    output logic       xip,
    output logic       xis,
    output logic       xid,
    output logic       wrx,
    output logic       rdx,
    output logic       abus_req,
    input  logic       abus_gnt
);

    localparam int c_RW = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [c_RW-1:0] r_rem;
    logic [3:0]      r_sel;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_req;
    logic            r_rdx;

    logic w_start;
    logic w_setup_last;
    logic w_pulse_last;
    logic w_strobe_done;
    logic w_tmo;

    assign w_start = ((r_state == ST_IDLE) && cmd_valid && is_write_op(cmd_op)) ||
                     ((r_state == ST_HOLD) && (r_op == OP_SHR) && (r_rem > c_RW'(1)));

    xreg_strobe_gen #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC)
    ) u_strobe (
        .clk         (clk),
        .nrst        (nrst),
        .start       (w_start),
        .wrx         (wrx),
        .setup_last  (w_setup_last),
        .pulse_last  (w_pulse_last),
        .strobe_done (w_strobe_done)
    );

`ifdef XREG_CTRL_GNT_TIMEOUT_EN
    logic [3:0] r_tmr;

    // Counts consecutive ungranted REQ cycles; any grant or exit restarts it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tmr <= 4'd0;
        end else if ((r_state == ST_REQ) && !abus_gnt) begin
            r_tmr <= r_tmr + 4'd1;
        end else begin
            r_tmr <= 4'd0;
        end
    end

    assign w_tmo = (r_state == ST_REQ) && (r_tmr == 4'(GNT_TIMEOUT - 1));
`else
    logic [3:0] w_unused_tmo;
    assign w_unused_tmo = 4'(GNT_TIMEOUT);
    assign w_tmo        = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_rem   <= '0;
            r_sel   <= SEL_NONE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_rdx   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_op    <= cmd_op;
                        r_rem   <= c_RW'(cmd_count);
                        case (cmd_op)
                            OP_CLR: begin r_sel <= SEL_ZERO;  r_state <= ST_SETUP; end
                            OP_LDP: begin r_sel <= SEL_P;     r_state <= ST_SETUP; end
                            OP_LDD: begin r_sel <= SEL_DATA;  r_state <= ST_SETUP; end
                            OP_SHR: begin
                                r_sel   <= SEL_SHIFT;
                                r_state <= ST_SETUP;
                                if (cmd_count == 4'd0) r_rem <= c_RW'(WIDTH);
                            end
                            OP_RD: begin
                                r_rem   <= c_RW'(cmd_count) + c_RW'(1);
                                r_req   <= 1'b1;
                                r_state <= ST_REQ;
                            end
                            OP_NOP: begin r_done <= 1'b1; r_state <= ST_DONE; end
                            default: begin
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    if (w_setup_last) r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (w_pulse_last) r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_strobe_done) begin
                        if ((r_op == OP_SHR) && (r_rem > c_RW'(1))) begin
                            r_rem   <= r_rem - c_RW'(1);
                            r_state <= ST_SETUP;
                        end else begin
                            r_sel   <= SEL_NONE;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (abus_gnt) begin
                        r_rdx   <= 1'b1;
                        r_state <= ST_DRIVE;
                    end else if (w_tmo) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DRIVE: begin
                    // rdx is high for every DRIVE cycle, so each one consumes a count
                    r_rem <= r_rem - c_RW'(1);
                    if (r_rem == c_RW'(1)) begin
                        r_rdx   <= 1'b0;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (!abus_gnt) begin
                        r_rdx   <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= SEL_NONE;
                    r_req   <= 1'b0;
                    r_rdx   <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign xiz       = r_sel[3];
    assign xip       = r_sel[2];
    assign xis       = r_sel[1];
    assign xid       = r_sel[0];
    assign rdx       = r_rdx;
    assign abus_req  = r_req;

endmodule
`default_nettype wire
